// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIXUP = 2'b10
    } md_state_e;

endpackage : muldiv_pkg

// File: rtl/muldiv_step.sv
// One iteration of the datapath: radix-2 shift-add multiply or restoring divide step.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] rem_next_c,
    output logic [WIDTH-1:0] lo_next_c
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        shifted    = {rem_in, lo_in[WIDTH-1]};
        ge         = (shifted >= {1'b0, operand});
        diff       = shifted[WIDTH-1:0] - operand;
        sum        = {1'b0, rem_in} + (lo_in[0] ? {1'b0, operand} : '0);
        rem_next_c = sum[WIDTH:1];
        lo_next_c  = {sum[0], lo_in[WIDTH-1:1]};
        // Remainder stays below the divisor, so the low WIDTH bits of diff are exact.
        if (mode_div) begin
            rem_next_c = ge ? diff : shifted[WIDTH-1:0];
            lo_next_c  = {lo_in[WIDTH-2:0], ge};
        end
    end

endmodule : muldiv_step

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers.
// Optional MULDIV_CANCEL_EN adds a cancel input that flushes an in-flight op.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MULDIV_CANCEL_EN
    input  logic             cancel,
`endif
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e state, state_d;
    logic [CW-1:0]    count, count_d;
    logic [WIDTH-1:0] acc_hi, acc_hi_d, acc_lo, acc_lo_d, operand, operand_d;
    logic             op_div, op_div_d, neg_res, neg_res_d, neg_rem, neg_rem_d;
    logic             zero_div, zero_div_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d, dbz_d;

    logic             cancel_c;
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] step_hi_c, step_lo_c;

`ifdef MULDIV_CANCEL_EN
    assign cancel_c = cancel;
`else
    assign cancel_c = 1'b0;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div   (op_div),
        .rem_in     (acc_hi),
        .lo_in      (acc_lo),
        .operand    (operand),
        .rem_next_c (step_hi_c),
        .lo_next_c  (step_lo_c)
    );

    // Next-state and datapath control
    always_comb begin
        state_d    = state;
        count_d    = count;
        acc_hi_d   = acc_hi;
        acc_lo_d   = acc_lo;
        operand_d  = operand;
        op_div_d   = op_div;
        neg_res_d  = neg_res;
        neg_rem_d  = neg_rem;
        zero_div_d = zero_div;
        hi_d       = hi;
        lo_d       = lo;
        busy_d     = busy;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        signed_op  = (op == MD_MULT) || (op == MD_DIV);
        a_neg      = signed_op & a[WIDTH-1];
        b_neg      = signed_op & b[WIDTH-1];
        mag_a      = a_neg ? -a : a;
        mag_b      = b_neg ? -b : b;
        prod       = {acc_hi, acc_lo};
        prod       = neg_res ? -prod : prod;
        quo        = neg_res ? -acc_lo : acc_lo;
        rem        = neg_rem ? -acc_hi : acc_hi;

        case (state)
            S_IDLE: begin
                if (start) begin
                    // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there.
                    op_div_d   = op[1];
                    acc_hi_d   = '0;
                    acc_lo_d   = op[1] ? mag_a : mag_b;
                    operand_d  = op[1] ? mag_b : mag_a;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    zero_div_d = op[1] && (b == '0);
                    count_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = S_CALC;
                end else begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            S_CALC: begin
                if (cancel_c) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_hi_d = step_hi_c;
                    acc_lo_d = step_lo_c;
                    count_d  = count + CW'(1);
                    if (count == LAST) state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!cancel_c) begin
                    done_d = 1'b1;
                    if (op_div) begin
                        // With b==0 every trial succeeds, so the remainder is the dividend itself.
                        hi_d  = rem;
                        lo_d  = zero_div ? '1 : quo;
                        dbz_d = zero_div;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            operand     <= '0;
            op_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_div    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            acc_hi      <= acc_hi_d;
            acc_lo      <= acc_lo_d;
            operand     <= operand_d;
            op_div      <= op_div_d;
            neg_res     <= neg_res_d;
            neg_rem     <= neg_rem_d;
            zero_div    <= zero_div_d;
            hi          <= hi_d;
            lo          <= lo_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: behavioural HI/LO model plus directed and random ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MULDIV_CANCEL_EN
        .cancel      (cancel),
`endif
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain 64-bit arithmetic.
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl, output logic rz);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rz = 1'b0;
        rh = 32'd0;
        rl = 32'd0;
        case (o)
            2'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF; rz = 1'b1;
                end else if (o == 2'd2) begin
                    q = sx / sy; r = sx % sy;
                    rl = 32'(q); rh = 32'(r);
                end else begin
                    rl = x / y; rh = x % y;
                end
            end
        endcase
    endfunction

    // Model state: reflects the DUT after the most recent rising edge.
    bit          m_valid = 1'b0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    logic        p_dbz = 1'b0;
    int          m_left = 0;

    // Compare on the falling edge, then advance the model with the inputs the next edge will see.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
        m_done = 1'b0;
        m_dbz  = 1'b0;
        if (reset) begin
            m_valid = 1'b1; m_busy = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
        end else if (m_busy) begin
            if (cancel) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_dbz = p_dbz; m_hi = p_hi; m_lo = p_lo;
                end
            end
        end else if (start) begin
            ref_op(op, a, b, p_hi, p_lo, p_dbz);
            m_busy = 1'b1;
            m_left = 33;
        end else begin
            if (mthi) m_hi = a;
            if (mtlo) m_lo = a;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_hi = 32'd0, r_lo = 32'd0;
    logic        r_dbz = 1'b0;

    // Issue one op, optionally with a second start plus mthi/mtlo in busy cycle 10.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit inj);
        int  bcnt, lat;
        bit  seen;
        op = o; a = x; b = y; start = 1'b1;
        tick;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        bcnt = 32'(busy);
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (inj && k == 9) begin
                start = 1'b1; op = 2'd2; a = $urandom; mthi = 1'b1; mtlo = 1'b1;
            end
            tick;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            bcnt += 32'(busy);
            if (done) begin
                seen = 1'b1; lat = k + 1; r_hi = hi; r_lo = lo; r_dbz = div_by_zero;
            end
        end
        chk("latency", 32'(lat), 32'd33);
        chk("busy_cycles", 32'(bcnt), 32'd33);
        tick;
        chk("done_width", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] eh, el, x, y;
        logic        ez;
        logic [1:0]  o;
        int          ndone, sel;

        repeat (2) tick;
        reset = 1'b0;
        tick;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_hi", r_hi, 32'hFFFF_FFFF);
        chk("mult_lo", r_lo, 32'hFFFF_FFEB);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_hi", r_hi, 32'hFFFF_FFFE);
        chk("multu_lo", r_lo, 32'h0000_0001);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo", r_lo, 32'hFFFF_FFFD);
        chk("div_hi", r_hi, 32'hFFFF_FFFF);
        run_op(2'd3, 32'd7, 32'd2, 1'b0);
        chk("divu_lo", r_lo, 32'd3);
        chk("divu_hi", r_hi, 32'd1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo", r_lo, 32'h8000_0000);
        chk("ovf_hi", r_hi, 32'd0);
        chk("ovf_flag", 32'(r_dbz), 32'd0);
        run_op(2'd3, 32'd5, 32'd0, 1'b0);
        chk("dbz_hi", r_hi, 32'd5);
        chk("dbz_lo", r_lo, 32'hFFFF_FFFF);
        chk("dbz_flag", 32'(r_dbz), 32'd1);
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
        chk("sdbz_hi", r_hi, 32'hFFFF_FFFB);

        run_op(2'd1, 32'h0001_0000, 32'h0003_0000, 1'b1);
        chk("busy_ignore_hi", r_hi, 32'd3);
        chk("busy_ignore_lo", r_lo, 32'd0);

        a = 32'h1234; mtlo = 1'b1;
        tick;
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi_kept", hi, 32'd3);

        op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1; mthi = 1'b1;
        tick;
        start = 1'b0; mthi = 1'b0;
        chk("start_beats_mthi", hi, 32'd3);
        for (int k = 0; k < 40 && busy; k++) tick;
        chk("divu_100_7_lo", lo, 32'd14);
        chk("divu_100_7_hi", hi, 32'd2);
        tick;

        op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (40) begin tick; ndone += 32'(done); end
        chk("midreset_no_done", 32'(ndone), 32'd0);

`ifdef MULDIV_CANCEL_EN
        a = 32'hAA; mthi = 1'b1;
        tick;
        mthi = 1'b0; a = 32'hBB; mtlo = 1'b1;
        tick;
        mtlo = 1'b0; op = 2'd2; a = 32'd100; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_hi", hi, 32'hAA);
        chk("cancel_lo", lo, 32'hBB);
        ndone = 0;
        repeat (40) begin tick; ndone += 32'(done); end
        chk("cancel_no_done", 32'(ndone), 32'd0);
`endif

        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = 32'd0;
            else if (sel == 1) y = $urandom_range(1, 15);
            else if (sel == 2) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel == 3) x = $urandom_range(0, 100);
            run_op(o, x, y, 1'b0);
            ref_op(o, x, y, eh, el, ez);
            chk("rand_hi", r_hi, eh);
            chk("rand_lo", r_lo, el);
            chk("rand_dbz", 32'(r_dbz), 32'(ez));
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom; mthi = 1'($urandom); mtlo = 1'($urandom);
                tick;
                mthi = 1'b0; mtlo = 1'b0;
            end
        end

        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_unit
